// File: rtl/cpu_run_controller_if.sv
// Memory/external-port bundle between the run controller, the CPU memory side,
// the 16x4 data memory and the switch/display loader front-end.
interface cpu_run_controller_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] cpu_m_add;
  logic [DATA_W-1:0] cpu_m_wd;
  logic              cpu_m_we;
  logic              cpu_m_re;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_add;
  logic [DATA_W-1:0] ext_wd;
  logic              ext_gnt;
  logic [ADDR_W-1:0] mem_add;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic              mem_re;

  modport slave (
    input  cpu_m_add, cpu_m_wd, cpu_m_we, cpu_m_re,
    input  ext_req, ext_we, ext_add, ext_wd,
    output ext_gnt, mem_add, mem_wd, mem_we, mem_re
  );

  modport master (
    output cpu_m_add, cpu_m_wd, cpu_m_we, cpu_m_re,
    output ext_req, ext_we, ext_add, ext_wd,
    input  ext_gnt, mem_add, mem_wd, mem_we, mem_re
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Halt / single-step / free-run sequencer and data-memory port owner for the CPU.
// Optional breakpoint logic is built when RUN_CTRL_BREAKPOINT_EN is defined.
module cpu_run_controller #(
  parameter int TICK_DIV = 50000000,
  parameter int PC_W     = 3,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_btn_i,
  input  logic                 step_btn_i,
  input  logic                 halt_btn_i,
  input  logic                 bp_en_i,
  input  logic [PC_W-1:0]      bp_pc_i,
  input  logic [PC_W-1:0]      pc_i,
  cpu_run_controller_if.slave  mem_if,
  output logic                 cpu_en_o,
  output logic [1:0]           state_o,
  output logic [7:0]           retired_o
);

  localparam logic [1:0] S_HALT = 2'b00;
  localparam logic [1:0] S_STEP = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;
  localparam logic [1:0] S_EXT  = 2'b11;

  localparam int             CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ext_gnt_q, ext_gnt_d;
  logic [7:0]       retired_q, retired_d;
  logic             en_raw_s;
  logic             en_s;
  logic             tick_s;
  logic             bp_hit_s;

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic armed_q, armed_d;
  assign bp_hit_s = bp_en_i & armed_q & (pc_i == bp_pc_i);
`else
  logic unused_bp_s;
  assign bp_hit_s    = 1'b0;
  assign unused_bp_s = ^{bp_en_i, bp_pc_i, pc_i};
`endif

  assign tick_s = (cnt_q == CNT_LAST);
  // Reset also suppresses the enable combinationally so a tick never fires while in reset.
  assign en_s   = en_raw_s & reset;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    en_raw_s = 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
    armed_d  = armed_q;
`endif
    case (state_q)
      S_HALT: begin
        cnt_d = '0;
        if (run_btn_i) begin
          state_d = S_RUN;
`ifdef RUN_CTRL_BREAKPOINT_EN
          armed_d = 1'b0;
`endif
        end else if (step_btn_i) begin
          state_d = S_STEP;
        end else if (mem_if.ext_req) begin
          state_d = S_EXT;
        end else begin
          state_d = S_HALT;
        end
      end
      S_STEP: begin
        en_raw_s = 1'b1;
        state_d  = S_HALT;
      end
      S_RUN: begin
        if (halt_btn_i) begin
          state_d = S_HALT;
          cnt_d   = '0;
        end else if (tick_s) begin
          cnt_d = '0;
          if (bp_hit_s) begin
            state_d = S_HALT;
          end else begin
            // Arming after the first executed instruction lets a run started on bp_pc move past it.
            en_raw_s = 1'b1;
`ifdef RUN_CTRL_BREAKPOINT_EN
            armed_d  = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EXT: begin
        if (!mem_if.ext_req) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXT;
        end
      end
      default: begin
        state_d = S_HALT;
        cnt_d   = '0;
      end
    endcase
    ext_gnt_d = (state_d == S_EXT);
    retired_d = en_s ? (retired_q + 8'd1) : retired_q;
  end

  // State, tick counter, grant and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_HALT;
      cnt_q     <= '0;
      ext_gnt_q <= 1'b0;
      retired_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ext_gnt_q <= ext_gnt_d;
      retired_q <= retired_d;
    end
  end

`ifdef RUN_CTRL_BREAKPOINT_EN
  // Breakpoint arm flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
    end
  end
`endif

  // Memory port mux: the loader owns memory only in EXT; CPU writes need the enable.
  always_comb begin
    if (state_q == S_EXT) begin
      mem_if.mem_add = mem_if.ext_add;
      mem_if.mem_wd  = mem_if.ext_wd;
      mem_if.mem_we  = mem_if.ext_we & mem_if.ext_req & reset;
      mem_if.mem_re  = 1'b1;
    end else begin
      mem_if.mem_add = mem_if.cpu_m_add;
      mem_if.mem_wd  = mem_if.cpu_m_wd;
      mem_if.mem_we  = mem_if.cpu_m_we & en_s;
      mem_if.mem_re  = mem_if.cpu_m_re;
    end
  end

  assign mem_if.ext_gnt = ext_gnt_q;
  assign cpu_en_o       = en_s;
  assign state_o        = state_q;
  assign retired_o      = retired_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller (TICK_DIV=4) against a cycle-level reference model.
module tb_cpu_run_controller;
  localparam int TICK_DIV = 4;
  localparam int PC_W = 3;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int M_HALT = 0;
  localparam int M_STEP = 1;
  localparam int M_RUN = 2;
  localparam int M_EXT = 3;

  logic clk = 1'b0;
  logic reset, run_btn, step_btn, halt_btn, bp_en;
  logic [PC_W-1:0] bp_pc, pc;
  logic cpu_en;
  logic [1:0] state;
  logic [7:0] retired;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: mode, cycles spent in the current run period, arm flag, executed count.
  int m_state = M_HALT;
  int m_phase = 0;
  bit m_armed = 1'b0;
  int m_ret = 0;
  logic exp_en, exp_gnt, exp_we, exp_re;
  logic [1:0] exp_state;
  logic [7:0] exp_ret;
  logic [ADDR_W-1:0] exp_add;
  logic [DATA_W-1:0] exp_wd;

  always #5 clk = ~clk;

  cpu_run_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cpu_run_controller #(
    .TICK_DIV(TICK_DIV), .PC_W(PC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset), .run_btn_i(run_btn), .step_btn_i(step_btn),
    .halt_btn_i(halt_btn), .bp_en_i(bp_en), .bp_pc_i(bp_pc), .pc_i(pc),
    .mem_if(bus.slave), .cpu_en_o(cpu_en), .state_o(state), .retired_o(retired)
  );

  function automatic bit m_bp_hit();
`ifdef RUN_CTRL_BREAKPOINT_EN
    return bp_en && m_armed && (pc == bp_pc);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_eval();
    exp_state = 2'(m_state);
    exp_ret = 8'(m_ret);
    exp_gnt = (m_state == M_EXT);
    if (m_state == M_STEP) exp_en = 1'b1;
    else if (m_state == M_RUN) exp_en = !halt_btn && (m_phase == TICK_DIV - 1) && !m_bp_hit();
    else exp_en = 1'b0;
    if (!reset) exp_en = 1'b0;
    if (m_state == M_EXT) begin
      exp_add = bus.ext_add; exp_wd = bus.ext_wd;
      exp_we = bus.ext_we & bus.ext_req & reset; exp_re = 1'b1;
    end else begin
      exp_add = bus.cpu_m_add; exp_wd = bus.cpu_m_wd;
      exp_we = bus.cpu_m_we & exp_en; exp_re = bus.cpu_m_re;
    end
  endtask

  task automatic model_advance();
    if (!reset) begin
      m_state = M_HALT; m_phase = 0; m_armed = 1'b0; m_ret = 0;
    end else begin
      if (exp_en) m_ret = (m_ret + 1) % 256;
      if (m_state == M_HALT) begin
        if (run_btn) begin m_state = M_RUN; m_phase = 0; m_armed = 1'b0; end
        else if (step_btn) m_state = M_STEP;
        else if (bus.ext_req) m_state = M_EXT;
      end else if (m_state == M_STEP) begin
        m_state = M_HALT;
      end else if (m_state == M_RUN) begin
        if (halt_btn || (m_phase == TICK_DIV - 1 && m_bp_hit())) m_state = M_HALT;
        else begin
          if (exp_en) m_armed = 1'b1;
          m_phase = (m_phase + 1) % TICK_DIV;
        end
      end else if (!bus.ext_req) begin
        m_state = M_HALT;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    run_btn = 1'b0; step_btn = 1'b0; halt_btn = 1'b0; bp_en = 1'b0;
    bp_pc = '0; pc = '0;
    bus.cpu_m_add = '0; bus.cpu_m_wd = '0; bus.cpu_m_we = 1'b0; bus.cpu_m_re = 1'b0;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_add = '0; bus.ext_wd = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    settle(); advance();
    settle(); advance();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    bus.cpu_m_we = 1'b1;
    settle();
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b expected 00", state); end
    n_checks++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en: got %b expected 0", cpu_en); end
    n_checks++; if (bus.ext_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_ext_gnt: got %b expected 0", bus.ext_gnt); end
    n_checks++; if (retired !== 8'd0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
    advance();
    reset = 1'b1;
  endtask

  task automatic test_run_tick();
    int seen;
    do_reset();
    bus.cpu_m_we = 1'b1;
    run_btn = 1'b1; settle(); advance(); run_btn = 1'b0;
    seen = 0;
    for (int i = 1; i <= 12; i++) begin
      bus.cpu_m_add = 4'($urandom_range(0, 15)); bus.cpu_m_wd = 4'($urandom_range(0, 15));
      settle();
      n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL run_state c%0d: got %b expected 10", i, state); end
      n_checks++; if (cpu_en !== ((i % 4) == 0)) begin n_fail++; $display("FAIL run_cpu_en c%0d: got %b expected %b", i, cpu_en, (i % 4) == 0); end
      n_checks++; if (bus.mem_we !== ((i % 4) == 0)) begin n_fail++; $display("FAIL run_mem_we c%0d: got %b expected %b", i, bus.mem_we, (i % 4) == 0); end
      n_checks++; if (bus.mem_add !== bus.cpu_m_add) begin n_fail++; $display("FAIL run_mem_add c%0d: got %h expected %h", i, bus.mem_add, bus.cpu_m_add); end
      if (cpu_en === 1'b1) seen++;
      advance();
    end
    settle();
    n_checks++; if (retired !== 8'd3) begin n_fail++; $display("FAIL run_retired12: got %0d expected 3", retired); end
    n_checks++; if (seen != 3) begin n_fail++; $display("FAIL run_en_count: got %0d expected 3", seen); end
    for (int i = 0; i < 8 && m_phase != TICK_DIV - 1; i++) begin settle(); advance(); end
    halt_btn = 1'b1; settle();
    n_checks++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL halt_on_tick_en: got %b expected 0", cpu_en); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL halt_on_tick_we: got %b expected 0", bus.mem_we); end
    advance(); halt_btn = 1'b0; settle();
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL halt_on_tick_state: got %b expected 00", state); end
    n_checks++; if (retired !== 8'd3) begin n_fail++; $display("FAIL halt_on_tick_retired: got %0d expected 3", retired); end
    bus.cpu_m_we = 1'b0;
  endtask

  task automatic test_step();
    do_reset();
    step_btn = 1'b1; settle();
    n_checks++; if (state !== 2'b00 || cpu_en !== 1'b0) begin n_fail++; $display("FAIL step_pre: got %b/%b expected 00/0", state, cpu_en); end
    advance(); step_btn = 1'b0; settle();
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL step_state: got %b expected 01", state); end
    n_checks++; if (cpu_en !== 1'b1) begin n_fail++; $display("FAIL step_cpu_en: got %b expected 1", cpu_en); end
    advance(); settle();
    n_checks++; if (state !== 2'b00 || cpu_en !== 1'b0) begin n_fail++; $display("FAIL step_post: got %b/%b expected 00/0", state, cpu_en); end
    n_checks++; if (retired !== 8'd1) begin n_fail++; $display("FAIL step_retired: got %0d expected 1", retired); end
    step_btn = 1'b1; run_btn = 1'b1; settle(); advance();
    step_btn = 1'b0; run_btn = 1'b0; settle();
    n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL step_run_priority: got %b expected 10", state); end
    halt_btn = 1'b1; settle(); advance(); halt_btn = 1'b0;
  endtask

  task automatic test_breakpoint();
    int execd;
    do_reset();
    bp_en = 1'b1; bp_pc = 3'd3; pc = 3'd0;
    run_btn = 1'b1; settle(); advance(); run_btn = 1'b0;
    execd = 0;
    for (int i = 1; i <= 16; i++) begin
      pc = 3'(execd);
      settle();
      n_checks++; if (cpu_en !== exp_en) begin n_fail++; $display("FAIL bp_sweep_en c%0d: got %b expected %b", i, cpu_en, exp_en); end
      if (cpu_en === 1'b1) execd++;
      advance();
    end
    pc = 3'(execd);
    settle();
`ifdef RUN_CTRL_BREAKPOINT_EN
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL bp_halt_state: got %b expected 00", state); end
    n_checks++; if (retired !== 8'd3) begin n_fail++; $display("FAIL bp_halt_retired: got %0d expected 3", retired); end
    pc = 3'd3;
    run_btn = 1'b1; settle(); advance(); run_btn = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      n_checks++; if (cpu_en !== (i == 4)) begin n_fail++; $display("FAIL bp_rerun_en c%0d: got %b expected %b", i, cpu_en, i == 4); end
      advance();
    end
`else
    n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL bp_ignored_state: got %b expected 10", state); end
    n_checks++; if (retired !== 8'd4) begin n_fail++; $display("FAIL bp_ignored_retired: got %0d expected 4", retired); end
`endif
    halt_btn = 1'b1; settle(); advance(); halt_btn = 1'b0;
    bp_en = 1'b0;
  endtask

  task automatic test_ext();
    do_reset();
    bus.cpu_m_we = 1'b1; bus.cpu_m_add = 4'h3;
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_add = 4'hA; bus.ext_wd = 4'h5;
    settle();
    n_checks++; if (bus.ext_gnt !== 1'b0) begin n_fail++; $display("FAIL ext_pre_gnt: got %b expected 0", bus.ext_gnt); end
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL ext_pre_we: got %b expected 0", bus.mem_we); end
    advance();
    run_btn = 1'b1; settle();
    n_checks++; if (bus.ext_gnt !== 1'b1 || state !== 2'b11) begin n_fail++; $display("FAIL ext_gnt: got %b/%b expected 1/11", bus.ext_gnt, state); end
    n_checks++; if (bus.mem_add !== 4'hA || bus.mem_wd !== 4'h5) begin n_fail++; $display("FAIL ext_mux: got %h/%h expected a/5", bus.mem_add, bus.mem_wd); end
    n_checks++; if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b1) begin n_fail++; $display("FAIL ext_we_re: got %b/%b expected 1/1", bus.mem_we, bus.mem_re); end
    advance(); run_btn = 1'b0; settle();
    n_checks++; if (state !== 2'b11) begin n_fail++; $display("FAIL ext_run_ignored: got %b expected 11", state); end
    bus.ext_req = 1'b0; settle();
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL ext_drop_we: got %b expected 0", bus.mem_we); end
    advance(); settle();
    n_checks++; if (state !== 2'b00 || bus.ext_gnt !== 1'b0) begin n_fail++; $display("FAIL ext_release: got %b/%b expected 00/0", state, bus.ext_gnt); end
    bus.cpu_m_we = 1'b0; bus.ext_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.ext_req = 1'b1; settle(); advance();
    reset = 1'b0; settle(); advance();
    reset = 1'b1; bus.ext_req = 1'b0; settle();
    n_checks++; if (state !== 2'b00 || bus.ext_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ext: got %b/%b expected 00/0", state, bus.ext_gnt); end
    run_btn = 1'b1; settle(); advance(); run_btn = 1'b0;
    for (int i = 0; i < 7; i++) begin settle(); advance(); end
    reset = 1'b0; settle();
    n_checks++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tick_en: got %b expected 0", cpu_en); end
    advance(); reset = 1'b1; settle();
    n_checks++; if (state !== 2'b00 || cpu_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_run: got %b/%b expected 00/0", state, cpu_en); end
    n_checks++; if (retired !== 8'd0 || bus.ext_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_mid_run_ret: got %0d/%b expected 0/0", retired, bus.ext_gnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 249) != 0);
      run_btn = ($urandom_range(0, 15) == 0);
      step_btn = ($urandom_range(0, 11) == 0);
      halt_btn = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) bus.ext_req = ~bus.ext_req;
      bus.ext_we = 1'($urandom); bus.ext_add = 4'($urandom); bus.ext_wd = 4'($urandom);
      bus.cpu_m_we = 1'($urandom); bus.cpu_m_re = 1'($urandom);
      bus.cpu_m_add = 4'($urandom); bus.cpu_m_wd = 4'($urandom);
      bp_en = ($urandom_range(0, 3) != 0); bp_pc = 3'($urandom); pc = 3'($urandom);
      settle();
      n_checks++; if (state !== exp_state) begin n_fail++; $display("FAIL rnd_state c%0d: got %b expected %b", i, state, exp_state); end
      n_checks++; if (cpu_en !== exp_en) begin n_fail++; $display("FAIL rnd_cpu_en c%0d: got %b expected %b", i, cpu_en, exp_en); end
      n_checks++; if (retired !== exp_ret) begin n_fail++; $display("FAIL rnd_retired c%0d: got %0d expected %0d", i, retired, exp_ret); end
      n_checks++; if (bus.ext_gnt !== exp_gnt) begin n_fail++; $display("FAIL rnd_ext_gnt c%0d: got %b expected %b", i, bus.ext_gnt, exp_gnt); end
      n_checks++; if (bus.mem_add !== exp_add || bus.mem_wd !== exp_wd) begin n_fail++; $display("FAIL rnd_mux c%0d: got %h/%h expected %h/%h", i, bus.mem_add, bus.mem_wd, exp_add, exp_wd); end
      n_checks++; if (bus.mem_we !== exp_we || bus.mem_re !== exp_re) begin n_fail++; $display("FAIL rnd_we_re c%0d: got %b/%b expected %b/%b", i, bus.mem_we, bus.mem_re, exp_we, exp_re); end
      advance();
    end
    reset = 1'b1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_run_tick();
    test_step();
    test_breakpoint();
    test_ext();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
